sd_cmd_sequencer: RTL and testbench
===================================

Name: sd_cmd_sequencer

Overview:
Byte-level SD-card SPI-mode command sequencer that sits directly above the SPI byte engine and drives it through its execute/finished handshake.
- Accepts one command request (index, argument, CRC) and frames it into the 6-byte SD command.
- Brackets the transfer with chip-select and 0xFF fill bytes, polls for the R1 response, and optionally collects a 4-byte R3/R7 trailer.
- Reports the result to the card-init / block-transfer logic above it.

Parameters:
- POLL_LIMIT, 8, max 0xFF poll bytes sent while waiting for R1 (NCR window); legal range 1..255.
- PRE_FILL, 1, number of 0xFF bytes sent with cs_n low before the command frame; legal range 0..15.

Ports:
- clk  in  1  system clock; also the byte engine clock.
- reset  in  1  asynchronous, active-high reset.
- cmd_valid  in  1  command request.
- cmd_ready  out  1  high in IDLE only; transfer occurs when cmd_valid && cmd_ready.
- cmd_index  in  6  SD command index.
- cmd_arg  in  32  command argument, sent MSB byte first.
- cmd_crc  in  7  CRC7 of the first 5 frame bytes.
- cmd_resp_long  in  1  read a 4-byte trailer after R1 (R3/R7).
- cmd_keep_cs  in  1  leave cs_n low after completion (data phase follows).
- resp_valid  out  1  one-cycle completion pulse.
- resp_r1  out  8  R1 byte, or 0xFF on timeout.
- resp_data  out  32  trailer bytes, first received byte in [31:24].
- resp_timeout  out  1  qualified by resp_valid.
- busy  out  1  high in every state except IDLE.
- cs_n  out  1  card chip select, active low.
- spi_execute  out  1  byte start to the engine.
- spi_out_word  out  8  byte to transmit.
- spi_in_word  in  8  received byte, valid when spi_finished is high.
- spi_finished  in  1  one-cycle end-of-byte pulse from the engine.

Behaviour:
- Reset values: cmd_ready=1, resp_valid=0, resp_r1=0xFF, resp_data=0, resp_timeout=0, busy=0, cs_n=1, spi_execute=0, spi_out_word=0xFF. The state machine returns to IDLE.
- All logic is clocked on posedge clk.
- Request capture: on acceptance, latch index, arg, crc, long and keep_cs into internal registers. Input changes after acceptance are ignored.
- Byte issue rule, common to all states:
  - Drive spi_out_word and pulse spi_execute high for exactly one cycle.
  - Hold spi_out_word stable until spi_finished is sampled high.
  - Issue the next byte no earlier than the cycle after spi_finished.
  - spi_finished seen in IDLE, or while no byte is outstanding, is ignored. This covers reset mid-byte.
- States:
  - IDLE: wait for accept. On accept, drive cs_n=0 and go to PRE, or to CMD if PRE_FILL=0.
  - PRE: send PRE_FILL bytes of 0xFF.
  - CMD: send 6 bytes in order: {2'b01,index}, arg[31:24], arg[23:16], arg[15:8], arg[7:0], {crc,1'b1}.
  - POLL: send 0xFF and examine spi_in_word at each spi_finished.
    - If bit7==0: latch resp_r1 and go to TAIL if long, else to POST.
    - If the POLL_LIMIT-th byte still has bit7==1: set resp_r1=0xFF, flag timeout, and go to POST.
  - TAIL: send four 0xFF bytes; shift each spi_in_word into resp_data, MSB byte first. TAIL is skipped on timeout.
  - POST: if keep_cs=0, send one 0xFF byte, then set cs_n=1. If keep_cs=1, skip the byte and leave cs_n=0.
  - DONE: pulse resp_valid for 1 cycle together with final resp_r1, resp_data and resp_timeout, then go to IDLE.
- Response outputs hold their values until the next DONE. resp_data is not updated for short commands or on timeout.
- cmd_valid asserted in the same cycle as DONE is not accepted. It is accepted at the earliest on the following cycle in IDLE.
- While cmd_keep_cs left cs_n low, a new accept keeps cs_n low without a glitch.
- Counters: 4-bit byte counter (PRE/CMD/TAIL) and 8-bit poll counter. Both clear on state entry; neither wraps.

Optional Feature:
- Macro SD_CMD_CRC7_GEN_EN.
- Defined: the block computes CRC7 (polynomial x^7+x^3+1, init 0) over the 5 header bytes at accept time, serially or combinationally. The computed value replaces the CRC field of the last frame byte, and cmd_crc is ignored.
- Undefined: the last frame byte is {cmd_crc,1'b1} and no CRC logic is synthesised.

Test Plan:
- CMD0, arg 0, crc 0x4A, PRE_FILL=1; card replies FF,01 -> MOSI bytes FF,40,00,00,00,00,95,FF(x2 poll),FF(post); resp_r1=0x01, timeout=0, cs_n=1 after, resp_valid single pulse.
- CMD8, arg 0x000001AA, crc 0x43, long=1; card replies FF,01,00,00,01,AA -> last frame byte 0x87; resp_r1=0x01, resp_data=0x000001AA.
- CMD17 with card silent (all 0xFF), POLL_LIMIT=8 -> exactly 8 poll bytes sent; resp_timeout=1, resp_r1=0xFF; resp_data keeps its prior value.
- keep_cs=1 followed by a back-to-back second command -> no post byte; cs_n stays 0 across both commands; cmd_ready low throughout each.
- Assert reset during the CMD-state 3rd byte -> all outputs at reset values; the stale spi_finished pulse is ignored; the next command runs correctly.
- With SD_CMD_CRC7_GEN_EN defined and cmd_crc=0: CMD0 arg 0 -> last byte 0x95; CMD8 arg 0x1AA -> last byte 0x87.

Source files
------------

// File: rtl/sd_cmd_sequencer.sv
// SD-card SPI-mode command sequencer: frames one command, polls R1, optionally reads an R3/R7 trailer.
// Define SD_CMD_CRC7_GEN_EN to compute the frame CRC7 internally instead of using cmd_crc.
module sd_cmd_sequencer #(
   parameter int unsigned POLL_LIMIT = 8,
   parameter int unsigned PRE_FILL   = 1
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        cmd_valid,
   output logic        cmd_ready,
   input  logic [5:0]  cmd_index,
   input  logic [31:0] cmd_arg,
   input  logic [6:0]  cmd_crc,
   input  logic        cmd_resp_long,
   input  logic        cmd_keep_cs,
   output logic        resp_valid,
   output logic [7:0]  resp_r1,
   output logic [31:0] resp_data,
   output logic        resp_timeout,
   output logic        busy,
   output logic        cs_n,
   output logic        spi_execute,
   output logic [7:0]  spi_out_word,
   input  logic [7:0]  spi_in_word,
   input  logic        spi_finished
);

   typedef enum logic [2:0] {
      S_IDLE,
      S_PRE,
      S_CMD,
      S_POLL,
      S_TAIL,
      S_POST,
      S_DONE
   } state_t;

   localparam logic [3:0] PRE_LAST  = (PRE_FILL == 0) ? 4'd0 : 4'(PRE_FILL - 1);
   localparam logic [7:0] POLL_LAST = 8'(POLL_LIMIT - 1);

   state_t      state_q, state_d;
   logic [3:0]  cnt_q, cnt_d;
   logic [7:0]  poll_q, poll_d;
   logic        pend_q, pend_d;
   logic        exec_q, exec_d;
   logic [7:0]  word_q, word_d;
   logic        cs_n_q, cs_n_d;

   logic [5:0]  idx_q;
   logic [31:0] arg_q;
   logic [6:0]  crc_q;
   logic        long_q;
   logic        keep_q;

   logic [7:0]  r1_w_q, r1_w_d;
   logic        to_w_q, to_w_d;
   logic [31:0] data_w_q, data_w_d;
   logic [7:0]  r1_q, r1_d;
   logic        to_q, to_d;
   logic [31:0] data_q, data_d;

   logic        accept;
   logic        fin;
   logic        tx_en;
   logic        go_done;
   logic [7:0]  tx_byte;
   logic [7:0]  frame_byte;
   logic [6:0]  crc_next;

`ifdef SD_CMD_CRC7_GEN_EN
   function automatic logic [6:0] crc7(input logic [39:0] d);
      logic [6:0] c;
      logic       fb;
      c = '0;
      for (int unsigned i = 0; i < 40; i++) begin
         fb = d[39 - i] ^ c[6];
         c  = {c[5:0], 1'b0} ^ {3'b000, fb, 2'b00, fb};
      end
      return c;
   endfunction

   logic unused_cmd_crc;
   assign unused_cmd_crc = ^cmd_crc;
   assign crc_next       = crc7({2'b01, cmd_index, cmd_arg});
`else
   assign crc_next = cmd_crc;
`endif

   assign accept     = cmd_valid && (state_q == S_IDLE);
   assign fin        = pend_q && spi_finished;
   assign cmd_ready  = (state_q == S_IDLE);
   assign busy       = (state_q != S_IDLE);
   assign resp_valid = (state_q == S_DONE);
   assign cs_n         = cs_n_q;
   assign spi_execute  = exec_q;
   assign spi_out_word = word_q;
   assign resp_r1      = r1_q;
   assign resp_timeout = to_q;
   assign resp_data    = data_q;

   always_comb begin
      frame_byte = 8'hFF;
      case (cnt_q)
         4'd0:    frame_byte = {2'b01, idx_q};
         4'd1:    frame_byte = arg_q[31:24];
         4'd2:    frame_byte = arg_q[23:16];
         4'd3:    frame_byte = arg_q[15:8];
         4'd4:    frame_byte = arg_q[7:0];
         4'd5:    frame_byte = {crc_q, 1'b1};
         default: frame_byte = 8'hFF;
      endcase
   end

   always_comb begin
      state_d  = state_q;
      cnt_d    = cnt_q;
      poll_d   = poll_q;
      pend_d   = pend_q;
      exec_d   = 1'b0;
      word_d   = word_q;
      cs_n_d   = cs_n_q;
      r1_w_d   = r1_w_q;
      to_w_d   = to_w_q;
      data_w_d = data_w_q;
      r1_d     = r1_q;
      to_d     = to_q;
      data_d   = data_q;
      tx_en    = 1'b0;
      tx_byte  = 8'hFF;
      go_done  = 1'b0;

      if (fin) pend_d = 1'b0;

      case (state_q)
         S_IDLE: begin
            if (cmd_valid) begin
               cs_n_d  = 1'b0;
               cnt_d   = '0;
               r1_w_d  = 8'hFF;
               to_w_d  = 1'b0;
               state_d = (PRE_FILL == 0) ? S_CMD : S_PRE;
            end
         end
         S_PRE: begin
            tx_en = 1'b1;
            if (fin) begin
               if (cnt_q == PRE_LAST) begin
                  cnt_d   = '0;
                  state_d = S_CMD;
               end else begin
                  cnt_d = cnt_q + 4'd1;
               end
            end
         end
         S_CMD: begin
            tx_en   = 1'b1;
            tx_byte = frame_byte;
            if (fin) begin
               if (cnt_q == 4'd5) begin
                  poll_d  = '0;
                  state_d = S_POLL;
               end else begin
                  cnt_d = cnt_q + 4'd1;
               end
            end
         end
         S_POLL: begin
            tx_en = 1'b1;
            if (fin) begin
               if (!spi_in_word[7]) begin
                  r1_w_d  = spi_in_word;
                  cnt_d   = '0;
                  state_d = long_q ? S_TAIL : S_POST;
               end else if (poll_q == POLL_LAST) begin
                  r1_w_d  = 8'hFF;
                  to_w_d  = 1'b1;
                  state_d = S_POST;
               end else begin
                  poll_d = poll_q + 8'd1;
               end
            end
         end
         S_TAIL: begin
            tx_en = 1'b1;
            if (fin) begin
               data_w_d = {data_w_q[23:0], spi_in_word};
               if (cnt_q == 4'd3) begin
                  state_d = S_POST;
               end else begin
                  cnt_d = cnt_q + 4'd1;
               end
            end
         end
         S_POST: begin
            if (keep_q) begin
               go_done = 1'b1;
            end else begin
               tx_en = 1'b1;
               if (fin) begin
                  cs_n_d  = 1'b1;
                  go_done = 1'b1;
               end
            end
         end
         S_DONE: state_d = S_IDLE;
         default: state_d = S_IDLE;
      endcase

      // A new byte may only start once the previous one has fully retired.
      if (tx_en && !pend_q) begin
         exec_d = 1'b1;
         word_d = tx_byte;
         pend_d = 1'b1;
      end

      if (go_done) begin
         state_d = S_DONE;
         r1_d    = r1_w_q;
         to_d    = to_w_q;
         if (long_q && !to_w_q) data_d = data_w_q;
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q  <= S_IDLE;
         cnt_q    <= '0;
         poll_q   <= '0;
         pend_q   <= 1'b0;
         exec_q   <= 1'b0;
         word_q   <= 8'hFF;
         cs_n_q   <= 1'b1;
         r1_w_q   <= 8'hFF;
         to_w_q   <= 1'b0;
         data_w_q <= '0;
         r1_q     <= 8'hFF;
         to_q     <= 1'b0;
         data_q   <= '0;
      end else begin
         state_q  <= state_d;
         cnt_q    <= cnt_d;
         poll_q   <= poll_d;
         pend_q   <= pend_d;
         exec_q   <= exec_d;
         word_q   <= word_d;
         cs_n_q   <= cs_n_d;
         r1_w_q   <= r1_w_d;
         to_w_q   <= to_w_d;
         data_w_q <= data_w_d;
         r1_q     <= r1_d;
         to_q     <= to_d;
         data_q   <= data_d;
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         idx_q  <= '0;
         arg_q  <= '0;
         crc_q  <= '0;
         long_q <= 1'b0;
         keep_q <= 1'b0;
      end else if (accept) begin
         idx_q  <= cmd_index;
         arg_q  <= cmd_arg;
         crc_q  <= crc_next;
         long_q <= cmd_resp_long;
         keep_q <= cmd_keep_cs;
      end
   end

endmodule

// File: tb/tb_sd_cmd_sequencer.sv
// Directed bench for sd_cmd_sequencer with a behavioural SPI byte engine.
module tb_sd_cmd_sequencer;

   logic        clk = 1'b0;
   logic        reset;
   logic        cmd_valid;
   logic        cmd_ready;
   logic [5:0]  cmd_index;
   logic [31:0] cmd_arg;
   logic [6:0]  cmd_crc;
   logic        cmd_resp_long;
   logic        cmd_keep_cs;
   logic        resp_valid;
   logic [7:0]  resp_r1;
   logic [31:0] resp_data;
   logic        resp_timeout;
   logic        busy;
   logic        cs_n;
   logic        spi_execute;
   logic [7:0]  spi_out_word;
   logic [7:0]  spi_in_word;
   logic        spi_finished;

   int vec_n = 0;
   int err_n = 0;

   logic [7:0] mosi_log [0:511];
   int         mosi_n = 0;
   logic [7:0] miso [0:63];
   int         miso_base = 0;
   int         miso_len = 0;

   logic [7:0]  cap_r1;
   logic [31:0] cap_data;
   logic        cap_to;
   int          pulses, cs_hi, rdy_hi;

   always #5 clk = ~clk;

   sd_cmd_sequencer #(.POLL_LIMIT(8), .PRE_FILL(1)) dut (
      .clk(clk), .reset(reset),
      .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
      .cmd_index(cmd_index), .cmd_arg(cmd_arg), .cmd_crc(cmd_crc),
      .cmd_resp_long(cmd_resp_long), .cmd_keep_cs(cmd_keep_cs),
      .resp_valid(resp_valid), .resp_r1(resp_r1), .resp_data(resp_data),
      .resp_timeout(resp_timeout), .busy(busy), .cs_n(cs_n),
      .spi_execute(spi_execute), .spi_out_word(spi_out_word),
      .spi_in_word(spi_in_word), .spi_finished(spi_finished)
   );

   // Byte engine: logs each started byte, answers from miso[] two cycles later.
   initial begin
      int k;
      logic [7:0] rep;
      spi_finished = 1'b0;
      spi_in_word  = 8'hFF;
      forever begin
         @(negedge clk);
         if (spi_execute === 1'b1) begin
            k = mosi_n - miso_base;
            if (mosi_n < 512) mosi_log[mosi_n] = spi_out_word;
            mosi_n = mosi_n + 1;
            rep = (k >= 0 && k < miso_len) ? miso[k] : 8'hFF;
            repeat (2) @(negedge clk);
            spi_in_word  = rep;
            spi_finished = 1'b1;
            @(negedge clk);
            spi_finished = 1'b0;
            spi_in_word  = 8'hFF;
         end
      end
   end

   task automatic set_miso(input int pre_ff, input logic [7:0] r0, r1, r2, r3, r4, r5, input int nrep);
      for (int i = 0; i < pre_ff; i++) miso[i] = 8'hFF;
      miso[pre_ff + 0] = r0; miso[pre_ff + 1] = r1; miso[pre_ff + 2] = r2;
      miso[pre_ff + 3] = r3; miso[pre_ff + 4] = r4; miso[pre_ff + 5] = r5;
      miso_len = pre_ff + nrep;
   endtask

   task automatic send_cmd(input logic [5:0] idx, input logic [31:0] arg, input logic [6:0] crc,
                           input logic lng, input logic keep);
      int t;
      miso_base = mosi_n;
      @(negedge clk);
      cmd_index = idx; cmd_arg = arg; cmd_crc = crc;
      cmd_resp_long = lng; cmd_keep_cs = keep;
      cmd_valid = 1'b1;
      t = 0;
      while (!cmd_ready && t < 200) begin
         @(negedge clk);
         t++;
      end
      vec_n++;
      if (!cmd_ready) begin
         err_n++;
         $display("FAIL accept_wait: cmd_ready=%b required 1 within 200 cycles", cmd_ready);
      end
      @(negedge clk);
      cmd_valid = 1'b0;
      cmd_index = $urandom_range(63, 0);
      cmd_arg   = $urandom;
      cmd_crc   = $urandom_range(127, 0);
   endtask

   task automatic wait_resp();
      int after;
      pulses = 0; cs_hi = 0; rdy_hi = 0; after = 0;
      for (int c = 0; c < 600 && after < 4; c++) begin
         @(negedge clk);
         if (resp_valid) begin
            pulses++;
            if (pulses == 1) begin
               cap_r1 = resp_r1; cap_data = resp_data; cap_to = resp_timeout;
            end
         end else if (pulses == 0) begin
            if (cs_n) cs_hi++;
            if (cmd_ready) rdy_hi++;
         end
         if (pulses > 0) after++;
      end
   endtask

   task automatic test_reset();
      reset = 1'b1;
      cmd_valid = 1'b0; cmd_index = '0; cmd_arg = '0; cmd_crc = '0;
      cmd_resp_long = 1'b0; cmd_keep_cs = 1'b0;
      repeat (3) @(negedge clk);
      vec_n++; if (cmd_ready !== 1'b1)    begin err_n++; $display("FAIL rst_ready: got %b want 1", cmd_ready); end
      vec_n++; if (resp_valid !== 1'b0)   begin err_n++; $display("FAIL rst_valid: got %b want 0", resp_valid); end
      vec_n++; if (resp_r1 !== 8'hFF)     begin err_n++; $display("FAIL rst_r1: got %h want ff", resp_r1); end
      vec_n++; if (resp_data !== 32'h0)   begin err_n++; $display("FAIL rst_data: got %h want 0", resp_data); end
      vec_n++; if (resp_timeout !== 1'b0) begin err_n++; $display("FAIL rst_timeout: got %b want 0", resp_timeout); end
      vec_n++; if (busy !== 1'b0)         begin err_n++; $display("FAIL rst_busy: got %b want 0", busy); end
      vec_n++; if (cs_n !== 1'b1)         begin err_n++; $display("FAIL rst_cs_n: got %b want 1", cs_n); end
      vec_n++; if (spi_execute !== 1'b0)  begin err_n++; $display("FAIL rst_exec: got %b want 0", spi_execute); end
      vec_n++; if (spi_out_word !== 8'hFF) begin err_n++; $display("FAIL rst_word: got %h want ff", spi_out_word); end
      reset = 1'b0;
      repeat (2) @(negedge clk);
   endtask

   task automatic test_cmd0();
      logic [7:0] exp [0:9];
      exp = '{8'hFF, 8'h40, 8'h00, 8'h00, 8'h00, 8'h00, 8'h95, 8'hFF, 8'hFF, 8'hFF};
      set_miso(7, 8'hFF, 8'h01, 8'hFF, 8'hFF, 8'hFF, 8'hFF, 2);
      send_cmd(6'd0, 32'h0, 7'h4A, 1'b0, 1'b0);
      wait_resp();
      vec_n++; if (pulses !== 1) begin err_n++; $display("FAIL cmd0_pulses: got %0d want 1", pulses); end
      vec_n++; if (cap_r1 !== 8'h01) begin err_n++; $display("FAIL cmd0_r1: got %h want 01", cap_r1); end
      vec_n++; if (cap_to !== 1'b0) begin err_n++; $display("FAIL cmd0_timeout: got %b want 0", cap_to); end
      vec_n++; if (cap_data !== 32'h0) begin err_n++; $display("FAIL cmd0_data: got %h want 0", cap_data); end
      vec_n++; if (cs_n !== 1'b1) begin err_n++; $display("FAIL cmd0_cs_after: got %b want 1", cs_n); end
      vec_n++; if (mosi_n - miso_base !== 10) begin err_n++; $display("FAIL cmd0_nbytes: got %0d want 10", mosi_n - miso_base); end
      for (int i = 0; i < 10; i++) begin
         vec_n++;
         if (mosi_log[miso_base + i] !== exp[i]) begin
            err_n++; $display("FAIL cmd0_byte%0d: got %h want %h", i, mosi_log[miso_base + i], exp[i]);
         end
      end
   endtask

   task automatic test_long();
      set_miso(7, 8'hFF, 8'h01, 8'h00, 8'h00, 8'h01, 8'hAA, 6);
      send_cmd(6'd8, 32'h0000_01AA, 7'h43, 1'b1, 1'b0);
      wait_resp();
      vec_n++; if (pulses !== 1) begin err_n++; $display("FAIL cmd8_pulses: got %0d want 1", pulses); end
      vec_n++; if (cap_r1 !== 8'h01) begin err_n++; $display("FAIL cmd8_r1: got %h want 01", cap_r1); end
      vec_n++; if (cap_data !== 32'h0000_01AA) begin err_n++; $display("FAIL cmd8_data: got %h want 000001aa", cap_data); end
      vec_n++; if (cap_to !== 1'b0) begin err_n++; $display("FAIL cmd8_timeout: got %b want 0", cap_to); end
      vec_n++; if (mosi_n - miso_base !== 14) begin err_n++; $display("FAIL cmd8_nbytes: got %0d want 14", mosi_n - miso_base); end
      vec_n++; if (mosi_log[miso_base + 1] !== 8'h48) begin err_n++; $display("FAIL cmd8_first: got %h want 48", mosi_log[miso_base + 1]); end
      vec_n++; if (mosi_log[miso_base + 6] !== 8'h87) begin err_n++; $display("FAIL cmd8_last: got %h want 87", mosi_log[miso_base + 6]); end
   endtask

   task automatic test_timeout();
      miso_len = 0;
      send_cmd(6'd17, 32'h0, 7'h2A, 1'b0, 1'b0);
      wait_resp();
      vec_n++; if (pulses !== 1) begin err_n++; $display("FAIL to_pulses: got %0d want 1", pulses); end
      vec_n++; if (cap_to !== 1'b1) begin err_n++; $display("FAIL to_flag: got %b want 1", cap_to); end
      vec_n++; if (cap_r1 !== 8'hFF) begin err_n++; $display("FAIL to_r1: got %h want ff", cap_r1); end
      vec_n++; if (cap_data !== 32'h0000_01AA) begin err_n++; $display("FAIL to_data_kept: got %h want 000001aa", cap_data); end
      // 1 pre + 6 frame + 8 poll + 1 post
      vec_n++; if (mosi_n - miso_base !== 16) begin err_n++; $display("FAIL to_nbytes: got %0d want 16", mosi_n - miso_base); end
      vec_n++; if (cs_n !== 1'b1) begin err_n++; $display("FAIL to_cs_after: got %b want 1", cs_n); end
   endtask

   task automatic test_back_to_back();
      set_miso(7, 8'h01, 8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'hFF, 1);
      send_cmd(6'd55, 32'h0, 7'h32, 1'b0, 1'b1);
      wait_resp();
      vec_n++; if (cap_r1 !== 8'h01) begin err_n++; $display("FAIL keepA_r1: got %h want 01", cap_r1); end
      vec_n++; if (mosi_n - miso_base !== 8) begin err_n++; $display("FAIL keepA_nbytes: got %0d want 8", mosi_n - miso_base); end
      vec_n++; if (cs_hi !== 0) begin err_n++; $display("FAIL keepA_cs: got %0d high cycles want 0", cs_hi); end
      vec_n++; if (rdy_hi !== 0) begin err_n++; $display("FAIL keepA_ready: got %0d ready cycles want 0", rdy_hi); end
      vec_n++; if (cs_n !== 1'b0) begin err_n++; $display("FAIL keepA_cs_after: got %b want 0", cs_n); end
      set_miso(7, 8'hFF, 8'hFF, 8'h00, 8'hFF, 8'hFF, 8'hFF, 3);
      send_cmd(6'd41, 32'h4000_0000, 7'h3B, 1'b0, 1'b0);
      wait_resp();
      vec_n++; if (cap_r1 !== 8'h00) begin err_n++; $display("FAIL keepB_r1: got %h want 00", cap_r1); end
      vec_n++; if (mosi_n - miso_base !== 11) begin err_n++; $display("FAIL keepB_nbytes: got %0d want 11", mosi_n - miso_base); end
      vec_n++; if (mosi_log[miso_base + 1] !== 8'h69) begin err_n++; $display("FAIL keepB_first: got %h want 69", mosi_log[miso_base + 1]); end
      vec_n++; if (cs_hi !== 0) begin err_n++; $display("FAIL keepB_cs: got %0d high cycles want 0", cs_hi); end
      vec_n++; if (rdy_hi !== 0) begin err_n++; $display("FAIL keepB_ready: got %0d ready cycles want 0", rdy_hi); end
      vec_n++; if (cs_n !== 1'b1) begin err_n++; $display("FAIL keepB_cs_after: got %b want 1", cs_n); end
   endtask

   task automatic test_reset_mid();
      int t;
      int n_at_rst;
      miso_len = 0;
      send_cmd(6'd17, 32'h0, 7'h2A, 1'b0, 1'b0);
      t = 0;
      while (mosi_n - miso_base < 4 && t < 200) begin
         @(negedge clk);
         t++;
      end
      reset = 1'b1;
      #1;
      n_at_rst = mosi_n;
      vec_n++; if (mosi_log[miso_base + 3] !== 8'h00) begin err_n++; $display("FAIL rmid_byte3: got %h want 00", mosi_log[miso_base + 3]); end
      vec_n++; if (busy !== 1'b0) begin err_n++; $display("FAIL rmid_busy: got %b want 0", busy); end
      vec_n++; if (cs_n !== 1'b1) begin err_n++; $display("FAIL rmid_cs_n: got %b want 1", cs_n); end
      vec_n++; if (spi_out_word !== 8'hFF) begin err_n++; $display("FAIL rmid_word: got %h want ff", spi_out_word); end
      vec_n++; if (resp_r1 !== 8'hFF) begin err_n++; $display("FAIL rmid_r1: got %h want ff", resp_r1); end
      vec_n++; if (resp_data !== 32'h0) begin err_n++; $display("FAIL rmid_data: got %h want 0", resp_data); end
      @(negedge clk);
      reset = 1'b0;
      repeat (6) @(negedge clk);
      vec_n++; if (mosi_n !== n_at_rst) begin err_n++; $display("FAIL rmid_stale: got %0d bytes want %0d", mosi_n, n_at_rst); end
      vec_n++; if (busy !== 1'b0) begin err_n++; $display("FAIL rmid_idle: got busy=%b want 0", busy); end
      set_miso(7, 8'hFF, 8'h01, 8'hFF, 8'hFF, 8'hFF, 8'hFF, 2);
      send_cmd(6'd0, 32'h0, 7'h4A, 1'b0, 1'b0);
      wait_resp();
      vec_n++; if (cap_r1 !== 8'h01) begin err_n++; $display("FAIL rmid_next_r1: got %h want 01", cap_r1); end
      vec_n++; if (mosi_n - miso_base !== 10) begin err_n++; $display("FAIL rmid_next_nbytes: got %0d want 10", mosi_n - miso_base); end
      vec_n++; if (mosi_log[miso_base + 6] !== 8'h95) begin err_n++; $display("FAIL rmid_next_last: got %h want 95", mosi_log[miso_base + 6]); end
   endtask

`ifdef SD_CMD_CRC7_GEN_EN
   task automatic test_crc_gen();
      set_miso(7, 8'hFF, 8'h01, 8'hFF, 8'hFF, 8'hFF, 8'hFF, 2);
      send_cmd(6'd0, 32'h0, 7'h00, 1'b0, 1'b0);
      wait_resp();
      vec_n++; if (mosi_log[miso_base + 6] !== 8'h95) begin err_n++; $display("FAIL crc_cmd0: got %h want 95", mosi_log[miso_base + 6]); end
      set_miso(7, 8'hFF, 8'h01, 8'h00, 8'h00, 8'h01, 8'hAA, 6);
      send_cmd(6'd8, 32'h0000_01AA, 7'h00, 1'b1, 1'b0);
      wait_resp();
      vec_n++; if (mosi_log[miso_base + 6] !== 8'h87) begin err_n++; $display("FAIL crc_cmd8: got %h want 87", mosi_log[miso_base + 6]); end
   endtask
`endif

   initial begin
      test_reset();
      test_cmd0();
      test_long();
      test_timeout();
      test_back_to_back();
      test_reset_mid();
`ifdef SD_CMD_CRC7_GEN_EN
      test_crc_gen();
`endif
      $display("== %0d vectors applied, %0d miscompares ==", vec_n, err_n);
      $finish;
   end

endmodule
